cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
- Multi-stage CIC interpolator. It takes samples at a low rate and produces samples at a high rate.
- It is the transmit-path counterpart of the receive-path CIC decimator and shares the same strobe-based rate scheme.
- A comb chain runs on the low-rate strobe and feeds a zero-stuffing upsampler. An integrator chain runs on the high-rate strobe.
- Typical use: between the baseband TX sample source and the DAC / upconverter interface.

Parameters:
- NUM_STAGES, 3, number of comb stages and number of integrator stages (N >= 1).
- STG_GSZ, 5, log2 of the interpolation ratio; R = 2^STG_GSZ.
- ISZ, 16, input word size (signed).
- OSZ, 16, output word size (signed); OSZ <= ISZ + (NUM_STAGES-1)*STG_GSZ.
- localparam ASZ = ISZ + NUM_STAGES*STG_GSZ, accumulator and comb word size.
- localparam GSZ = (NUM_STAGES-1)*STG_GSZ, filter DC gain exponent (gain = R^(N-1) = 2^GSZ).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_rate  in  1  low-rate strobe, one clk wide; legal only on a cycle where out_rate is also high, once per R out_rate strobes.
- out_rate  in  1  high-rate strobe, one clk wide.
- in  in  ISZ  signed input sample, sampled on in_rate.
- out  out  OSZ  signed output sample.
- out_valid  out  1  one-clk pulse when out updates.
- rate_err  out  1  sticky flag: in_rate was seen without out_rate.

Behaviour:
- Reset (reset=0, async): all comb, integrator and upsampler registers go to 0; out=0, out_valid=0, rate_err=0. Applies immediately mid-stream; operation restarts from zero state on release.
- Valid low-rate cycle: a clk edge with in_rate=1 and out_rate=1.
- Illegal strobe: in_rate=1 with out_rate=0 is ignored (no state change) and sets rate_err. rate_err clears only on reset.
- Comb chain, updated on valid low-rate cycles only:
  - comb_diff[0] <= sign-extend(in) to ASZ.
  - For j=1..N: comb_diff[j] <= comb_diff[j-1] - comb_dly[j-1] and comb_dly[j-1] <= comb_diff[j-1].
  - All stages update in the same edge (pipelined). A sample reaches comb_diff[N] N low-rate strobes after entry.
- Upsampler register us, updated on every out_rate edge:
  - us <= comb_diff[N] (its pre-update value) if in_rate is also high.
  - Otherwise us <= 0 (zero-stuffing, R-1 zeros per sample).
- Integrators, updated on every out_rate edge: integ[0] <= integ[0] + us; integ[i] <= integ[i] + integ[i-1] for i=1..N-1.
- Arithmetic: two's complement, ASZ bits, wrap-around on overflow. The wrap is intentional and self-cancelling in CIC structure; no saturation in the integrators.
- Output, on each out_rate edge:
  - out <= integ[N-1][ISZ+GSZ-1 : ISZ+GSZ-OSZ], i.e. divide by the DC gain, then truncate the low bits.
  - out_valid pulses 1 the same edge; otherwise 0.
- DC gain is unity: constant input x settles to out = x (for OSZ = ISZ).
- Latency from the in_rate strobe accepting a sample to its first out effect: L = (N+1)*R + N + 1 out_rate strobes. For N=3, R=4: L = 20.
- No back-pressure: one output per out_rate strobe, one input per in_rate strobe.

Optional Feature:
- Macro CIC_INTERP_ROUND_EN.
- Defined: before slicing, add 2^(ISZ+GSZ-OSZ-1) to integ[N-1] (round half up). The add is combinational in the output register path, so latency is unchanged. If ISZ+GSZ == OSZ, no add is performed.
- Undefined: plain truncation as above.
- rate_err and all other behaviour are identical in both builds.

Test Plan:
- Common configuration for all tests: N=3, STG_GSZ=2, ISZ=OSZ=16. in_rate on every 4th out_rate strobe unless stated.
- Reset: hold reset=0 with random in and strobes -> out=0, out_valid=0, rate_err=0. Release -> out stays 0 while in=0.
- DC step: in=1000 constant -> out settles to exactly 1000 and stays there; out_valid pulses every out_rate.
- Impulse:
  - Stimulus: in=16384 for one in_rate, 0 thereafter.
  - First nonzero out is 1024, on the 20th out_rate after the impulse strobe.
  - Response returns to 0 and stays 0 after the response length.
- Negative full scale: in=-32768 constant -> out settles to -32768, no wrap artefacts. Then in=+32767 -> settles to 32767.
- Illegal strobe: pulse in_rate with out_rate=0 -> rate_err=1 sticky, filter state unchanged. Later legal traffic still produces correct DC output.
- Rounding, in the CIC_INTERP_ROUND_EN build with OSZ=12:
  - Stimulus: in=24 DC.
  - Required: out=2 with the macro (1.5 rounded up); out=1 without it.

Source files
------------

// File: rtl/cic_interpolator.sv
// Multi-stage CIC interpolator: comb chain on the low-rate strobe, zero-stuffing upsampler,
// integrator chain on the high-rate strobe. Define CIC_INTERP_ROUND_EN for round-half-up output.
module cic_interpolator #(
  parameter int NUM_STAGES = 3,
  parameter int STG_GSZ    = 5,
  parameter int ISZ        = 16,
  parameter int OSZ        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_rate,
  input  logic                  out_rate,
  input  logic signed [ISZ-1:0] in,
  output logic signed [OSZ-1:0] out,
  output logic                  out_valid,
  output logic                  rate_err
);
  localparam int ASZ = ISZ + NUM_STAGES*STG_GSZ;
  localparam int GSZ = (NUM_STAGES-1)*STG_GSZ;
  localparam int LSB = ISZ + GSZ - OSZ;

  logic                           lo_vld;
  logic [NUM_STAGES:0][ASZ-1:0]   comb_diff;
  logic [NUM_STAGES-1:0][ASZ-1:0] comb_dly;
  logic [NUM_STAGES-1:0][ASZ-1:0] integ;
  logic [ASZ-1:0]                 us;
  logic [ASZ-1:0]                 out_acc;

  assign lo_vld = in_rate & out_rate;

  // Comb stages all shift together; wrap-around is cancelled by the integrators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comb_diff <= '0;
      comb_dly  <= '0;
    end else if (lo_vld) begin
      comb_diff[0] <= {{(ASZ-ISZ){in[ISZ-1]}}, in};
      for (int j = 1; j <= NUM_STAGES; j++) begin
        comb_diff[j]  <= comb_diff[j-1] - comb_dly[j-1];
        comb_dly[j-1] <= comb_diff[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      us    <= '0;
      integ <= '0;
    end else if (out_rate) begin
      us       <= in_rate ? comb_diff[NUM_STAGES] : '0;
      integ[0] <= integ[0] + us;
      for (int i = 1; i < NUM_STAGES; i++)
        integ[i] <= integ[i] + integ[i-1];
    end
  end

`ifdef CIC_INTERP_ROUND_EN
  if (LSB > 0) begin : g_rnd
    assign out_acc = integ[NUM_STAGES-1] + (ASZ'(1) << (LSB-1));
  end else begin : g_nornd
    assign out_acc = integ[NUM_STAGES-1];
  end
`else
  assign out_acc = integ[NUM_STAGES-1];
`endif

  // Divide by the DC gain 2^GSZ, then drop the low bits down to OSZ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      rate_err  <= 1'b0;
    end else begin
      out_valid <= out_rate;
      if (out_rate) out <= OSZ'(out_acc >> LSB);
      if (in_rate && !out_rate) rate_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (N=3, R=4, ISZ=OSZ=16, plus an OSZ=12 instance for rounding).
module tb_cic_interpolator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_rate = 1'b0;
  logic out_rate = 1'b0;
  logic signed [15:0] in_s = '0;
  logic signed [15:0] out;
  logic signed [11:0] out12;
  logic out_valid, rate_err, out_valid12, rate_err12;

  int total = 0;
  int bad = 0;
  int outq[$];
  int out12q[$];

`ifdef CIC_INTERP_ROUND_EN
  localparam int RND_EXP = 2;
`else
  localparam int RND_EXP = 1;
`endif

  typedef struct {
    logic signed [15:0] x;
    int n;
    int exp;
  } dc_t;

  cic_interpolator #(.NUM_STAGES(3), .STG_GSZ(2), .ISZ(16), .OSZ(16)) dut (
    .clk(clk), .reset(reset), .in_rate(in_rate), .out_rate(out_rate), .in(in_s),
    .out(out), .out_valid(out_valid), .rate_err(rate_err));

  cic_interpolator #(.NUM_STAGES(3), .STG_GSZ(2), .ISZ(16), .OSZ(12)) dut12 (
    .clk(clk), .reset(reset), .in_rate(in_rate), .out_rate(out_rate), .in(in_s),
    .out(out12), .out_valid(out_valid12), .rate_err(rate_err12));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit o, input bit i, input logic signed [15:0] x);
    @(negedge clk);
    out_rate = o;
    in_rate  = i;
    in_s     = x;
    @(posedge clk);
    #1;
  endtask

  // One out_rate strobe followed by one idle cycle.
  task automatic hs(input bit lo, input logic signed [15:0] x);
    tick(1'b1, lo, x);
    outq.push_back(int'(out));
    out12q.push_back(int'(out12));
    chk("valid_hi", int'(out_valid), 1);
    tick(1'b0, 1'b0, x);
    chk("valid_lo", int'(out_valid), 0);
  endtask

  task automatic period(input logic signed [15:0] x);
    hs(1'b1, x);
    repeat (3) hs(1'b0, x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    reset = 1'b1;
  endtask

  initial begin
    dc_t tv[5];
    int h[10];
    int e;
    tv[0] = '{x: 16'sd1000,  n: 12, exp: 1000};
    tv[1] = '{x: -16'sd32768, n: 12, exp: -32768};
    tv[2] = '{x: 16'sd32767, n: 12, exp: 32767};
    tv[3] = '{x: -16'sd5,    n: 12, exp: -5};
    tv[4] = '{x: 16'sd0,     n: 12, exp: 0};
    h = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

    // Reset held with random traffic
    for (int k = 0; k < 10; k++) begin
      tick(1'($urandom), 1'($urandom), 16'($urandom));
      chk("rst_out", int'(out), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_err", int'(rate_err), 0);
    end
    reset = 1'b1;
    outq.delete();
    repeat (8) period(16'sd0);
    foreach (outq[k]) chk("rel_zero", outq[k], 0);

    // DC table: settled outputs over the last two periods
    for (int v = 0; v < 5; v++) begin
      outq.delete();
      repeat (tv[v].n) period(tv[v].x);
      for (int k = outq.size() - 8; k < outq.size(); k++)
        chk($sformatf("dc%0d", v), outq[k], tv[v].exp);
    end

    // Impulse, after a mid-stream reset
    do_reset();
    chk("imp_rst_out", int'(out), 0);
    outq.delete();
    hs(1'b1, 16'sd16384);
    repeat (3) hs(1'b0, 16'sd0);
    repeat (10) period(16'sd0);
    for (int k = 0; k < outq.size(); k++) begin
      e = (k >= 20 && k < 30) ? h[k-20] * 1024 : 0;
      chk($sformatf("imp%0d", k), outq[k], e);
    end

    // Illegal strobe: ignored, sticky flag
    repeat (12) period(16'sd500);
    chk("err_before", int'(rate_err), 0);
    tick(1'b0, 1'b1, 16'sd12345);
    chk("err_set", int'(rate_err), 1);
    outq.delete();
    repeat (4) period(16'sd500);
    foreach (outq[k]) chk("err_hold_dc", outq[k], 500);
    chk("err_sticky", int'(rate_err), 1);
    outq.delete();
    repeat (12) period(-16'sd700);
    for (int k = outq.size() - 8; k < outq.size(); k++)
      chk("err_dc_neg", outq[k], -700);
    chk("err_sticky2", int'(rate_err), 1);
    do_reset();
    chk("err_clr", int'(rate_err), 0);

    // Rounding on the 12-bit output instance
    outq.delete();
    out12q.delete();
    repeat (12) period(16'sd24);
    for (int k = out12q.size() - 4; k < out12q.size(); k++) begin
      chk("rnd12", out12q[k], RND_EXP);
      chk("rnd16", outq[k], 24);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
